// File: rtl/adder_32_seq.sv
// ============================================================================
// Module   : adder_32_seq (with helper adder_4_cla)
// Brief    : Sequential WIDTH-bit add/subtract built from one 4-bit CLA slice
//            reused over WIDTH/4 cycles, LSB slice first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_4_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    always_comb begin
        w_g    = a & b;
        w_p    = a ^ b;
        w_c[0] = cin;
        w_c[1] = w_g[0] | (w_p[0] & cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & cin);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
        s      = w_p ^ w_c[3:0];
        cout   = w_c[4];
    end
endmodule

module adder_32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int                 c_N     = WIDTH / 4;
    localparam int                 c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(c_N - 1);
    localparam logic [c_IDX_W-1:0] c_ONE   = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_zero;
    logic [3:0]         w_s;
    logic               w_cout;
    logic               w_last;

    adder_4_cla u_slice (
        .a    (r_a[{r_idx, 2'b00} +: 4]),
        .b    (r_b[{r_idx, 2'b00} +: 4]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_last = (r_idx == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_BUSY;
            S_BUSY: begin
                if (abort)       w_state_next = S_IDLE;
                else if (w_last) w_state_next = S_DONE;
            end
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_b     <= op_sub ? ~op_b : op_b;
                        r_carry <= op_sub;
                        r_idx   <= '0;
                    end
                end
                S_BUSY: begin
                    if (!abort) begin
                        r_sum[{r_idx, 2'b00} +: 4] <= w_s;
                        r_carry                    <= w_cout;
                        r_idx                      <= r_idx + c_ONE;
                        if (w_last) begin
                            // Lower slices are already final, so the new top slice completes the flags.
                            r_cout <= w_cout;
                            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
                            r_zero <= (r_sum[WIDTH-5:0] == '0) && (w_s == 4'd0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule

`default_nettype wire

// File: tb/tb_adder_32_seq.sv
// ============================================================================
// Module   : tb_adder_32_seq
// Brief    : Directed self-checking bench for adder_32_seq at WIDTH = 32.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_32_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sub;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    adder_32_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation and wait for out_valid; leaves the DUT in DONE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub);
        int cnt;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        op_a     = a;
        op_b     = b;
        op_sub   = sub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        cnt      = 0;
        while (!out_valid && cnt < 20) begin
            step();
            cnt++;
        end
        check({tag, "_latency"}, cnt, 8);
    endtask

    task automatic check_res(input string tag, input logic [31:0] s, input logic c,
                             input logic o, input logic z);
        check({tag, "_sum"},  sum,  s);
        check({tag, "_cout"}, cout, c);
        check({tag, "_ovf"},  ovf,  o);
        check({tag, "_zero"}, zero, z);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check_res("rst", 32'h0, 1'b0, 1'b0, 1'b0);
        #11;
        rst_n = 1'b1;
        step();

        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check_res("add_wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        step();

        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        step();

        run_op("sub_5_7", 32'd5, 32'd7, 1'b1);
        check_res("sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        step();

        run_op("sub_7_5", 32'd7, 32'd5, 1'b1);
        check_res("sub_7_5", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        step();

        run_op("sub_min", 32'h8000_0000, 32'd1, 1'b1);
        check_res("sub_min", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        step();

        // Back-pressure in DONE, with stray in_valid pulses and an abort.
        out_ready = 1'b0;
        run_op("hold", 32'd1, 32'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i != 1);
            op_a     = 32'hDEAD_0000 + i;
            abort    = (i == 2);
            step();
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_in_ready",  in_ready,  1'b0);
            check_res("hold", 32'd3, 1'b0, 1'b0, 1'b0);
        end
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        step();
        check("release_in_ready",  in_ready,  1'b1);
        check("release_out_valid", out_valid, 1'b0);
        check("idle_keeps_sum",    sum,       32'd3);
        out_ready = 1'b1;

        // Abort while slice index 3 is pending.
        op_a     = 32'hAAAA_AAAA;
        op_b     = 32'h5555_5555;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("abort_no_valid", out_valid, 1'b0);
            step();
        end
        run_op("post_abort", 32'h1234_5678, 32'h1111_1111, 1'b0);
        check_res("post_abort", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        step();

        // Asynchronous reset between edges mid-operation.
        op_a     = 32'hFFFF_0000;
        op_b     = 32'h0001_0000;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready",  in_ready,  1'b1);
        check("arst_sum",       sum,       32'h0);
        step();
        #3;
        rst_n = 1'b1;
        step();
        run_op("post_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0);
        check_res("post_rst", 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        step();
        check("final_in_ready", in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
